// File: rtl/aes_encryption_iterative.sv
// rtl/aes_encryption_iterative.sv - iterative AES-128 encryption core, one round per clock
module aes_encryption_iterative #(
  parameter int numRounds = 10
) (
  input  logic         clock,
  input  logic         resetModule_n,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic         busy,
  output logic [127:0] outputData,
  output logic         dataEncryptedFlag
);

  generate
    if (numRounds != 10) begin : g_bad_rounds
      $error("aes_encryption_iterative supports only numRounds = 10");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(numRounds);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = a;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         busy_d;
  logic         flag_d;
  logic [127:0] out_d;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] round_out;
  logic [127:0] final_out;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  sched_t;
  logic [31:0]  nk0, nk1, nk2, nk3;
  logic [127:0] next_key;
  logic [7:0]   rcon;

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_state_sbox
    assign sub_bytes[127 - 8*gi -: 8] = sbox(state_q[127 - 8*gi -: 8]);
  end

  assign rot_word = {key_q[23:0], key_q[31:24]};
  for (gi = 0; gi < 4; gi++) begin : g_key_sbox
    assign sub_word[31 - 8*gi -: 8] = sbox(rot_word[31 - 8*gi -: 8]);
  end

  // Round constant for the round currently being computed
  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign sched_t  = sub_word ^ {rcon, 24'h000000};
  assign nk0      = key_q[127:96] ^ sched_t;
  assign nk1      = key_q[95:64]  ^ nk0;
  assign nk2      = key_q[63:32]  ^ nk1;
  assign nk3      = key_q[31:0]   ^ nk2;
  assign next_key = {nk0, nk1, nk2, nk3};

  assign shifted   = shift_rows(sub_bytes);
  assign round_out = mix_columns(shifted) ^ next_key;
  assign final_out = shifted ^ next_key;

  // Next-state and datapath update; any unexpected state/round combination falls back to IDLE
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    busy_d  = busy;
    flag_d  = 1'b0;
    out_d   = outputData;
    case (fsm_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (inputsLoadedFlag) begin
          state_d = inputData ^ key;
          key_d   = key;
          round_d = 4'd1;
          fsm_d   = ST_ROUND;
          busy_d  = 1'b1;
        end
      end
      ST_ROUND: begin
        if (round_q >= 4'd1 && round_q <= LAST_ROUND - 4'd1) begin
          state_d = round_out;
          key_d   = next_key;
          round_d = round_q + 4'd1;
          if (round_q == LAST_ROUND - 4'd1) fsm_d = ST_FINAL;
        end else begin
          fsm_d   = ST_IDLE;
          busy_d  = 1'b0;
          round_d = 4'd0;
        end
      end
      ST_FINAL: begin
        if (round_q == LAST_ROUND) begin
          state_d = final_out;
          out_d   = final_out;
          flag_d  = 1'b1;
        end
        fsm_d   = ST_IDLE;
        busy_d  = 1'b0;
        round_d = 4'd0;
      end
      default: begin
        fsm_d   = ST_IDLE;
        busy_d  = 1'b0;
        round_d = 4'd0;
      end
    endcase
  end

  // Registers; reset discards any block in flight and clears the result
  always_ff @(posedge clock or negedge resetModule_n) begin
    if (!resetModule_n) begin
      fsm_q             <= ST_IDLE;
      state_q           <= '0;
      key_q             <= '0;
      round_q           <= 4'd0;
      busy              <= 1'b0;
      outputData        <= '0;
      dataEncryptedFlag <= 1'b0;
    end else begin
      fsm_q             <= fsm_d;
      state_q           <= state_d;
      key_q             <= key_d;
      round_q           <= round_d;
      busy              <= busy_d;
      outputData        <= out_d;
      dataEncryptedFlag <= flag_d;
    end
  end

endmodule

// File: tb/tb_aes_encryption_iterative.sv
// tb/tb_aes_encryption_iterative.sv - randomized self-checking bench for aes_encryption_iterative
module tb_aes_encryption_iterative;

  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clock = 1'b0;
  logic         resetModule_n;
  logic [127:0] inputData;
  logic [127:0] key;
  logic         inputsLoadedFlag;
  logic         busy;
  logic [127:0] outputData;
  logic         dataEncryptedFlag;

  int passed = 0;
  int total  = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  aes_encryption_iterative #(.numRounds(10)) dut (
    .clock             (clock),
    .resetModule_n     (resetModule_n),
    .inputData         (inputData),
    .key               (key),
    .inputsLoadedFlag  (inputsLoadedFlag),
    .busy              (busy),
    .outputData        (outputData),
    .dataEncryptedFlag (dataEncryptedFlag)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x]  = s;
      isbox_t[s] = x[7:0];
    end
  endtask

  function automatic void expand_key(input logic [127:0] k, output logic [127:0] rk [11]);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] rk [11];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] st;
    expand_key(k, rk);
    st = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_t[st[127 - 8*b -: 8]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row + 4*col] = s[row + 4*((col + row) % 4)];
      if (r != 10) begin
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++)
            s[row + 4*col] = gmul(8'h02, t[row + 4*col]) ^ gmul(8'h03, t[(row+1)%4 + 4*col])
                           ^ t[(row+2)%4 + 4*col] ^ t[(row+3)%4 + 4*col];
      end else begin
        s = t;
      end
      for (int b = 0; b < 16; b++) st[127 - 8*b -: 8] = s[b];
      st = st ^ rk[r];
    end
    return st;
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [127:0] rk [11];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] st;
    expand_key(k, rk);
    st = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      for (int b = 0; b < 16; b++) s[b] = st[127 - 8*b -: 8];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row + 4*((col + row) % 4)] = s[row + 4*col];
      for (int b = 0; b < 16; b++) st[127 - 8*b -: 8] = isbox_t[t[b]];
      st = st ^ rk[r];
      if (r > 0) begin
        for (int b = 0; b < 16; b++) s[b] = st[127 - 8*b -: 8];
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++)
            t[row + 4*col] = gmul(8'h0e, s[row + 4*col]) ^ gmul(8'h0b, s[(row+1)%4 + 4*col])
                           ^ gmul(8'h0d, s[(row+2)%4 + 4*col]) ^ gmul(8'h09, s[(row+3)%4 + 4*col]);
        for (int b = 0; b < 16; b++) st[127 - 8*b -: 8] = t[b];
      end
    end
    return st;
  endfunction

  // Accept one block, scramble the inputs, wait (bounded) for the completion pulse
  task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output int lat, output logic busy_acc);
    inputData        = pt;
    key              = k;
    inputsLoadedFlag = 1'b1;
    tick();
    busy_acc         = busy;
    inputsLoadedFlag = 1'b0;
    inputData        = {$urandom, $urandom, $urandom, $urandom};
    key              = {$urandom, $urandom, $urandom, $urandom};
    lat = -1;
    ct  = 'x;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (dataEncryptedFlag === 1'b1) begin
        lat = i;
        ct  = outputData;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetModule_n    = 1'b0;
    inputsLoadedFlag = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (outputData !== 128'h0) $display("FAIL reset_out: got %h expected 0", outputData); else passed++;
    total++; if (dataEncryptedFlag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", dataEncryptedFlag); else passed++;
    inputsLoadedFlag = 1'b0;
    resetModule_n    = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0 || dataEncryptedFlag !== 1'b0)
      $display("FAIL reset_idle: got busy=%b flag=%b expected 0/0", busy, dataEncryptedFlag); else passed++;
  endtask

  task automatic test_known_vectors();
    logic [127:0] pts [3];
    logic [127:0] keys [3];
    logic [127:0] cts [3];
    logic [127:0] ct;
    int           lat;
    logic         b;
    pts[0] = V1_PT;  keys[0] = V1_KEY; cts[0] = V1_CT;
    pts[1] = V2_PT;  keys[1] = V2_KEY; cts[1] = V2_CT;
    pts[2] = '0;     keys[2] = '0;     cts[2] = Z_CT;
    for (int v = 0; v < 3; v++) begin
      run_block(pts[v], keys[v], ct, lat, b);
      total++; if (b !== 1'b1) $display("FAIL kv%0d_busy: got %b expected 1", v, b); else passed++;
      total++; if (lat != 10) $display("FAIL kv%0d_latency: got %0d expected 10", v, lat); else passed++;
      total++; if (ct !== cts[v]) $display("FAIL kv%0d_ct: got %h expected %h", v, ct, cts[v]); else passed++;
      tick();
      total++; if (dataEncryptedFlag !== 1'b0) $display("FAIL kv%0d_pulse: got %b expected 0", v, dataEncryptedFlag); else passed++;
      total++; if (outputData !== cts[v]) $display("FAIL kv%0d_hold: got %h expected %h", v, outputData, cts[v]); else passed++;
      if (v == 2) begin
        total++; if (model_decrypt(ct, 128'h0) !== 128'h0)
          $display("FAIL kv_roundtrip: got %h expected 0", model_decrypt(ct, 128'h0)); else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, k, ct, exp_ct;
    int           lat;
    logic         b;
    for (int n = 0; n < 6; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = model_encrypt(pt, k);
      run_block(pt, k, ct, lat, b);
      total++; if (lat != 10) $display("FAIL rand%0d_latency: got %0d expected 10", n, lat); else passed++;
      total++; if (ct !== exp_ct) $display("FAIL rand%0d_ct: got %h expected %h", n, ct, exp_ct); else passed++;
      total++; if (model_decrypt(ct, k) !== pt)
        $display("FAIL rand%0d_roundtrip: got %h expected %h", n, model_decrypt(ct, k), pt); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [127:0] pa, ka, pb, kb, exp_ct, ct;
    int           npulse, lat;
    pa = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    exp_ct = model_encrypt(pa, ka);
    inputData = pa; key = ka; inputsLoadedFlag = 1'b1;
    tick();
    npulse = 0; lat = -1; ct = 'x;
    for (int i = 1; i <= 25; i++) begin
      inputsLoadedFlag = (i == 3 || i == 7);
      inputData = pb;
      key       = kb;
      tick();
      if (dataEncryptedFlag === 1'b1) begin
        npulse++;
        if (lat < 0) begin lat = i; ct = outputData; end
      end
    end
    inputsLoadedFlag = 1'b0;
    total++; if (npulse != 1) $display("FAIL ignore_pulses: got %0d expected 1", npulse); else passed++;
    total++; if (lat != 10) $display("FAIL ignore_latency: got %0d expected 10", lat); else passed++;
    total++; if (ct !== exp_ct) $display("FAIL ignore_ct: got %h expected %h", ct, exp_ct); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [2];
    logic [127:0] keys [2];
    logic [127:0] cts [2];
    logic         exp_flag;
    pts[0] = V1_PT; keys[0] = V1_KEY; cts[0] = V1_CT;
    pts[1] = V2_PT; keys[1] = V2_KEY; cts[1] = V2_CT;
    inputData = pts[0]; key = keys[0]; inputsLoadedFlag = 1'b1;
    for (int c = 0; c < 44; c++) begin
      tick();
      if (c % 11 == 0) begin
        inputData = pts[((c / 11) + 1) % 2];
        key       = keys[((c / 11) + 1) % 2];
      end
      if (c == 43) inputsLoadedFlag = 1'b0;
      exp_flag = (c % 11 == 10);
      total++; if (dataEncryptedFlag !== exp_flag)
        $display("FAIL b2b_flag_c%0d: got %b expected %b", c, dataEncryptedFlag, exp_flag); else passed++;
      total++; if (busy !== !exp_flag)
        $display("FAIL b2b_busy_c%0d: got %b expected %b", c, busy, !exp_flag); else passed++;
      if (exp_flag) begin
        total++; if (outputData !== cts[(c / 11) % 2])
          $display("FAIL b2b_ct_c%0d: got %h expected %h", c, outputData, cts[(c / 11) % 2]); else passed++;
      end
    end
    tick();
    total++; if (busy !== 1'b0 || dataEncryptedFlag !== 1'b0)
      $display("FAIL b2b_stop: got busy=%b flag=%b expected 0/0", busy, dataEncryptedFlag); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct;
    int           lat, npulse;
    logic         b;
    inputData = V1_PT; key = V1_KEY; inputsLoadedFlag = 1'b1;
    tick();
    inputsLoadedFlag = 1'b0;
    repeat (5) tick();
    resetModule_n = 1'b0;
    #1;
    total++; if (outputData !== 128'h0) $display("FAIL mid_out: got %h expected 0", outputData); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
    total++; if (dataEncryptedFlag !== 1'b0) $display("FAIL mid_flag: got %b expected 0", dataEncryptedFlag); else passed++;
    npulse = 0;
    repeat (3) begin tick(); if (dataEncryptedFlag === 1'b1) npulse++; end
    resetModule_n = 1'b1;
    repeat (15) begin tick(); if (dataEncryptedFlag === 1'b1) npulse++; end
    total++; if (npulse != 0) $display("FAIL mid_no_pulse: got %0d expected 0", npulse); else passed++;
    run_block(V1_PT, V1_KEY, ct, lat, b);
    total++; if (lat != 10) $display("FAIL mid_rerun_latency: got %0d expected 10", lat); else passed++;
    total++; if (ct !== V1_CT) $display("FAIL mid_rerun_ct: got %h expected %h", ct, V1_CT); else passed++;
  endtask

  initial begin
    resetModule_n    = 1'b0;
    inputsLoadedFlag = 1'b0;
    inputData        = '0;
    key              = '0;
    build_sbox();
    test_reset();
    test_known_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
